// File: rtl/muldiv_pkg.sv
// Shared types, Funct3 encodings and decode helpers for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // MULHSU treats rs2 as unsigned, so it is absent here.
    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step on a
// double-width accumulator {high, low}.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic                mode,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     operand,
    output logic [2*XLEN-1:0]   next_acc
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;
    logic            ge;

    always_comb begin
        sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        // The shifted partial remainder can need one extra bit before the compare.
        rem_sh = acc[2*XLEN-1:XLEN-1];
        ge     = rem_sh >= {1'b0, operand};
        diff   = rem_sh[XLEN-1:0] - operand;
        if (mode) begin
            if (ge) begin
                next_acc = {diff, acc[XLEN-2:0], 1'b1};
            end else begin
                next_acc = {acc[2*XLEN-2:0], 1'b0};
            end
        end else begin
            next_acc = {sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide unit: magnitude prep, XLEN iterations of muldiv_step,
// then a sign fix-up into a registered result. Stalls the pipeline while busy.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Start,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            Flush,
    output logic            Stall,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result
);

    localparam int CNTW = $clog2(XLEN) + 1;

    state_t              state;
    logic [2:0]          op_f3;
    logic [XLEN-1:0]     op_a;
    logic [XLEN-1:0]     op_b;
    logic [XLEN-1:0]     operand;
    logic [2*XLEN-1:0]   acc;
    logic [2*XLEN-1:0]   step_acc;
    logic                neg_res;
    logic [CNTW-1:0]     cnt;

    logic                accept;
    logic                sign_a;
    logic                sign_b;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic                div_zero;
    logic                div_ovf;
    logic [XLEN-1:0]     special_word;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     word;
    logic [XLEN-1:0]     fix_word;

    assign accept = Start & ((state == S_IDLE) || (state == S_DONE)) & ~Flush;
    assign Stall  = accept | (state == S_PREP) | (state == S_RUN) | (state == S_FIX);
    assign Busy   = (state != S_IDLE);

    always_comb begin
        sign_a   = is_signed_a(op_f3) & op_a[XLEN-1];
        sign_b   = is_signed_b(op_f3) & op_b[XLEN-1];
        mag_a    = sign_a ? -op_a : op_a;
        mag_b    = sign_b ? -op_b : op_b;
        div_zero = (op_b == {XLEN{1'b0}});
        div_ovf  = ((op_f3 == F3_DIV) || (op_f3 == F3_REM))
                   && (op_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (op_b == {XLEN{1'b1}});
        // Overflow quotient equals the dividend (most negative value).
        if (div_zero) begin
            special_word = op_f3[1] ? op_a : {XLEN{1'b1}};
        end else begin
            special_word = op_f3[1] ? {XLEN{1'b0}} : op_a;
        end
    end

    always_comb begin
        prod = neg_res ? -acc : acc;
        word = op_f3[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        if (is_div(op_f3)) begin
            fix_word = neg_res ? -word : word;
        end else begin
            fix_word = (op_f3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    muldiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .mode     (is_div(op_f3)),
        .acc      (acc),
        .operand  (operand),
        .next_acc (step_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op_f3   <= 3'b000;
            op_a    <= {XLEN{1'b0}};
            op_b    <= {XLEN{1'b0}};
            operand <= {XLEN{1'b0}};
            acc     <= {(2*XLEN){1'b0}};
            neg_res <= 1'b0;
            cnt     <= {CNTW{1'b0}};
            Done    <= 1'b0;
            Result  <= {XLEN{1'b0}};
        end else if (Flush) begin
            state <= S_IDLE;
            Done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        op_f3 <= Funct3;
                        op_a  <= SrcA;
                        op_b  <= SrcB;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (is_div(op_f3) && (div_zero || div_ovf)) begin
                        Result <= special_word;
                        Done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        if (is_div(op_f3)) begin
                            acc     <= {{XLEN{1'b0}}, mag_a};
                            operand <= mag_b;
                            neg_res <= op_f3[1] ? sign_a : (sign_a ^ sign_b);
                        end else begin
                            acc     <= {{XLEN{1'b0}}, mag_b};
                            operand <= mag_a;
                            neg_res <= sign_a ^ sign_b;
                        end
                        cnt   <= CNTW'(XLEN);
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc <= step_acc;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNTW'(1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    Result <= fix_word;
                    Done   <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        op_f3 <= Funct3;
                        op_a  <= SrcA;
                        op_b  <= SrcB;
                        state <= S_PREP;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and randomized checks of muldiv_sequencer with a result/latency scoreboard.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic        Flush = 1'b0;
    logic [2:0]  Funct3 = 3'b000;
    logic [31:0] SrcA = 32'd0;
    logic [31:0] SrcB = 32'd0;
    logic        Stall;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Start  (Start),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Flush  (Flush),
        .Stall  (Stall),
        .Busy   (Busy),
        .Done   (Done),
        .Result (Result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb2, ua, ub;
        logic [63:0] r;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        r   = 64'd0;
        case (f3)
            F3_MUL, F3_MULH: r = sa * sb2;
            F3_MULHSU:       r = sa * ub;
            F3_MULHU:        r = ua * ub;
            F3_DIV: begin
                if (b == 32'd0) r = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, a};
                else r = sa / sb2;
            end
            F3_DIVU: begin
                if (b == 32'd0) r = '1;
                else r = ua / ub;
            end
            F3_REM: begin
                if (b == 32'd0) r = {32'd0, a};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 64'd0;
                else r = sa % sb2;
            end
            default: begin
                if (b == 32'd0) r = {32'd0, a};
                else r = ua % ub;
            end
        endcase
        if (f3 == F3_MUL || f3[2]) return r[31:0];
        return r[63:32];
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 32'd0) return 2;
        if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 35;
    endfunction

    // Called at a falling edge; the request is accepted at the following rising edge.
    task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input int lat);
        exp_t e;
        Funct3 = f3;
        SrcA   = a;
        SrcB   = b;
        Start  = 1'b1;
        e.tag = tag;
        e.res = res;
        e.lat = lat;
        sb.push_back(e);
        #1;
        chk({tag, " stall_cycle0"}, {31'd0, Stall}, 32'd1);
    endtask

    // Returns at the falling edge where Done is seen (or after the cycle budget).
    task automatic wait_done();
        exp_t e;
        int   k;
        logic stall_ok;
        e = sb.pop_front();
        stall_ok = 1'b1;
        for (k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 1) begin
                Start  = 1'b0;
                SrcA   = $urandom;
                SrcB   = $urandom;
                Funct3 = 3'($urandom_range(0, 7));
            end
            if (Done) break;
            if (!Stall) stall_ok = 1'b0;
        end
        chk({e.tag, " latency"}, 32'(k), 32'(e.lat));
        chk({e.tag, " result"}, Result, e.res);
        chk({e.tag, " stall_held"}, {31'd0, stall_ok}, 32'd1);
        chk({e.tag, " stall_at_done"}, {31'd0, Stall}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input int lat);
        issue(tag, f3, a, b, res, lat);
        wait_done();
        @(negedge clk);
        chk({tag, " done_one_shot"}, {31'd0, Done}, 32'd0);
        chk({tag, " idle_after"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        logic        seen_done;

        #2;
        chk("reset result", Result, 32'd0);
        chk("reset busy", {31'd0, Busy}, 32'd0);
        chk("reset done", {31'd0, Done}, 32'd0);
        chk("reset stall", {31'd0, Stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("MUL 7*6",      F3_MUL,    32'd7,          32'd6,          32'd42,         35);
        run_op("MUL -3*5",     F3_MUL,    32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  35);
        run_op("MULH",         F3_MULH,   32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  35);
        run_op("MULHU",        F3_MULHU,  32'hFFFF_FFFE,  32'd3,          32'h0000_0002,  35);
        run_op("MULHSU",       F3_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  35);
        run_op("MULH min*min", F3_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  35);
        run_op("DIV -7/2",     F3_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  35);
        run_op("REM -7/2",     F3_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  35);
        run_op("DIV 7/-2",     F3_DIV,    32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  35);
        run_op("REM 7/-2",     F3_REM,    32'd7,          32'hFFFF_FFFE,  32'd1,          35);
        run_op("DIVU 100/7",   F3_DIVU,   32'd100,        32'd7,          32'd14,         35);
        run_op("REMU 100/7",   F3_REMU,   32'd100,        32'd7,          32'd2,          35);
        run_op("DIVU big",     F3_DIVU,   32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  35);
        run_op("DIVU 7/0",     F3_DIVU,   32'd7,          32'd0,          32'hFFFF_FFFF,  2);
        run_op("REMU 7/0",     F3_REMU,   32'd7,          32'd0,          32'd7,          2);
        run_op("DIV -5/0",     F3_DIV,    32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  2);
        run_op("REM -5/0",     F3_REM,    32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  2);
        run_op("DIV ovf",      F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2);
        run_op("REM ovf",      F3_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2);

        // Back-to-back: new Start while in DONE goes straight to PREP.
        issue("B2B first", F3_DIVU, 32'd100, 32'd7, 32'd14, 35);
        wait_done();
        issue("B2B second", F3_REMU, 32'd100, 32'd7, 32'd2, 35);
        wait_done();
        @(negedge clk);
        chk("B2B idle_after", {31'd0, Busy}, 32'd0);

        // Flush in RUN: back to IDLE, no Done, Result keeps 2.
        Funct3 = F3_MUL;
        SrcA = 32'd5;
        SrcB = 32'd9;
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (10) @(negedge clk);
        chk("flush busy_before", {31'd0, Busy}, 32'd1);
        Flush = 1'b1;
        #1;
        chk("flush stall_in_run", {31'd0, Stall}, 32'd1);
        @(negedge clk);
        Flush = 1'b0;
        chk("flush busy_after", {31'd0, Busy}, 32'd0);
        chk("flush stall_after", {31'd0, Stall}, 32'd0);
        chk("flush result_kept", Result, 32'd2);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (Done) seen_done = 1'b1;
        end
        chk("flush no_done", {31'd0, seen_done}, 32'd0);

        // Flush beats a simultaneous Start.
        Start = 1'b1;
        Flush = 1'b1;
        #1;
        chk("flush_vs_start stall", {31'd0, Stall}, 32'd0);
        @(negedge clk);
        Start = 1'b0;
        Flush = 1'b0;
        chk("flush_vs_start busy", {31'd0, Busy}, 32'd0);
        chk("flush_vs_start result", Result, 32'd2);

        for (int i = 0; i < 8; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if (i == 3) rb = 32'd0;
            if (i == 5) rb = 32'($urandom_range(1, 15));
            run_op("RND", rf3, ra, rb, ref_result(rf3, ra, rb), ref_lat(rf3, ra, rb));
        end

        run_op("PRE 3*5", F3_MUL, 32'd3, 32'd5, 32'd15, 35);

        // Async reset mid-RUN clears outputs without a clock edge.
        Funct3 = F3_MULHU;
        SrcA = 32'hDEAD_BEEF;
        SrcB = 32'h1234_5678;
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid result", Result, 32'd0);
        chk("rst_mid busy", {31'd0, Busy}, 32'd0);
        chk("rst_mid done", {31'd0, Done}, 32'd0);
        chk("rst_mid stall", {31'd0, Stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("POST DIV -100/7", F3_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 35);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
